// File: rtl/level_trigger_pkg.sv
// Shared types and the per-word lane qualification used by the level trigger.
// The qualifier takes its geometry as arguments, so one function serves any lane layout.
package level_trigger_pkg;

    typedef enum logic [1:0] {ARM, ACTIVE, HOLDOFF} state_t;

    localparam int MAX_LANES    = 32;
    localparam int MAX_SAMPLE_W = 32;
    localparam int MAX_DATA_W   = MAX_LANES * MAX_SAMPLE_W;

    // Strict compare on each of the first `lanes` samples, then AND (all_lanes) or OR across them.
    function automatic logic lane_qualify(
        input logic [MAX_DATA_W-1:0]   samples,
        input logic [MAX_SAMPLE_W-1:0] threshold,
        input logic                    above,
        input logic                    all_lanes,
        input int                      lanes,
        input int                      sample_w
    );
        logic                    any_hit;
        logic                    all_hit;
        logic                    lane_hit;
        logic [MAX_SAMPLE_W-1:0] mask;
        logic [MAX_SAMPLE_W-1:0] s;
        any_hit = 1'b0;
        all_hit = 1'b1;
        mask    = (sample_w >= MAX_SAMPLE_W) ? '1
                : MAX_SAMPLE_W'((64'(1) << sample_w) - 64'(1));
        for (int k = 0; k < MAX_LANES; k++) begin
            s        = MAX_SAMPLE_W'(samples >> (k * sample_w)) & mask;
            lane_hit = above ? (s > threshold) : (s < threshold);
            if (k < lanes) begin
                any_hit = any_hit | lane_hit;
                all_hit = all_hit & lane_hit;
            end
        end
        return all_lanes ? all_hit : any_hit;
    endfunction

endpackage

// File: rtl/consec_counter.sv
// Saturating counter of consecutive qualifying valid words; done flags the completing word.
// The count clears itself on completion, on a non-qualifying word, or on clr.
module consec_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             valid,
    input  logic             hit,
    input  logic [CNT_W-1:0] target,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] target_eff;
    logic [CNT_W:0]   count_inc;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        target_eff = (target == '0) ? CNT_W'(1) : target;
        count_inc  = {1'b0, count_q} + (CNT_W+1)'(1);
        done       = valid && hit && !clr && (count_inc >= {1'b0, target_eff});
        count_d    = count_q;
        if (clr) begin
            count_d = '0;
        end else if (valid) begin
            if (!hit || done) begin
                count_d = '0;
            end else if (!count_inc[CNT_W]) begin
                count_d = count_inc[CNT_W-1:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/level_trigger.sv
// Multi-lane ADC level trigger: ARM -> ACTIVE -> HOLDOFF with registered sync, edge pulses
// and a wrapping event counter.
module level_trigger
    import level_trigger_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int LANES    = 2,
    parameter int CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [LANES*SAMPLE_W-1:0] adc_data,
    input  logic                      adc_data_valid,
    input  logic [SAMPLE_W-1:0]       start_threshold,
    input  logic [SAMPLE_W-1:0]       stop_threshold,
    input  logic [CNT_W-1:0]          start_samples_number,
    input  logic [CNT_W-1:0]          stop_samples_number,
    input  logic [CNT_W-1:0]          holdoff_words,
    input  logic                      polarity,
    input  logic                      all_lanes,
    output logic                      sync,
    output logic                      sync_start,
    output logic                      sync_stop,
    output logic [CNT_W-1:0]          event_count
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] event_count_q, event_count_d;
    logic             sync_q, sync_d;
    logic             sync_start_q, sync_start_d;
    logic             sync_stop_q, sync_stop_d;
    logic             start_hit, stop_hit;
    logic             cnt_clr, cnt_hit, cnt_done;
    logic [CNT_W-1:0] cnt_target;

    // One counter serves both phases; it is held clear while disabled or in holdoff.
    always_comb begin
        start_hit  = lane_qualify(MAX_DATA_W'(adc_data), MAX_SAMPLE_W'(start_threshold),
                                  polarity, all_lanes, LANES, SAMPLE_W);
        stop_hit   = lane_qualify(MAX_DATA_W'(adc_data), MAX_SAMPLE_W'(stop_threshold),
                                  !polarity, all_lanes, LANES, SAMPLE_W);
        cnt_clr    = !enable || (state_q == HOLDOFF);
        cnt_hit    = (state_q == ARM) ? start_hit : stop_hit;
        cnt_target = (state_q == ARM) ? start_samples_number : stop_samples_number;
    end

    consec_counter #(
        .CNT_W (CNT_W)
    ) u_qcnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .valid  (adc_data_valid),
        .hit    (cnt_hit),
        .target (cnt_target),
        .done   (cnt_done),
        .count  ()
    );

    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        event_count_d = event_count_q;
        sync_start_d  = 1'b0;
        sync_stop_d   = 1'b0;
        if (!enable) begin
            state_d = ARM;
            hcnt_d  = '0;
        end else begin
            unique case (state_q)
                ARM: begin
                    if (cnt_done) begin
                        state_d       = ACTIVE;
                        sync_start_d  = 1'b1;
                        event_count_d = event_count_q + CNT_W'(1);
                    end
                end
                ACTIVE: begin
                    if (cnt_done) begin
                        state_d     = HOLDOFF;
                        hcnt_d      = holdoff_words;
                        sync_stop_d = 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (hcnt_q == '0) begin
                        state_d = ARM;
                    end else if (adc_data_valid) begin
                        hcnt_d = hcnt_q - CNT_W'(1);
                        if (hcnt_q == CNT_W'(1)) state_d = ARM;
                    end
                end
                default: state_d = ARM;
            endcase
        end
        sync_d = (state_d == ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ARM;
            hcnt_q        <= '0;
            event_count_q <= '0;
            sync_q        <= 1'b0;
            sync_start_q  <= 1'b0;
            sync_stop_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            event_count_q <= event_count_d;
            sync_q        <= sync_d;
            sync_start_q  <= sync_start_d;
            sync_stop_q   <= sync_stop_d;
        end
    end

    assign sync        = sync_q;
    assign sync_start  = sync_start_q;
    assign sync_stop   = sync_stop_q;
    assign event_count = event_count_q;

endmodule

// File: tb/tb_level_trigger.sv
// Directed plus randomised bench for level_trigger with a per-cycle scoreboard
// fed by an independent behavioural model.
module tb_level_trigger;

    localparam int SAMPLE_W = 16;
    localparam int LANES    = 2;
    localparam int CNT_W    = 32;

    logic                      clk;
    logic                      reset;
    logic                      enable;
    logic [LANES*SAMPLE_W-1:0] adc_data;
    logic                      adc_data_valid;
    logic [SAMPLE_W-1:0]       start_threshold;
    logic [SAMPLE_W-1:0]       stop_threshold;
    logic [CNT_W-1:0]          start_samples_number;
    logic [CNT_W-1:0]          stop_samples_number;
    logic [CNT_W-1:0]          holdoff_words;
    logic                      polarity;
    logic                      all_lanes;
    logic                      sync;
    logic                      sync_start;
    logic                      sync_stop;
    logic [CNT_W-1:0]          event_count;

    level_trigger #(
        .SAMPLE_W (SAMPLE_W),
        .LANES    (LANES),
        .CNT_W    (CNT_W)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .enable               (enable),
        .adc_data             (adc_data),
        .adc_data_valid       (adc_data_valid),
        .start_threshold      (start_threshold),
        .stop_threshold       (stop_threshold),
        .start_samples_number (start_samples_number),
        .stop_samples_number  (stop_samples_number),
        .holdoff_words        (holdoff_words),
        .polarity             (polarity),
        .all_lanes            (all_lanes),
        .sync                 (sync),
        .sync_start           (sync_start),
        .sync_stop            (sync_stop),
        .event_count          (event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic        sync;
        logic        start;
        logic        stop;
        logic [31:0] ev;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Behavioural reference: 0 = armed, 1 = active, 2 = holdoff.
    int              m_state = 0;
    longint unsigned m_q     = 0;
    longint unsigned m_h     = 0;
    logic [31:0]     m_ev    = '0;

    function automatic logic qual(input logic [31:0] data, input logic [15:0] th,
                                  input logic above, input logic all);
        logic any_ok, all_ok, h;
        logic [15:0] s;
        any_ok = 1'b0;
        all_ok = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            s = data[k*16 +: 16];
            h = above ? (s > th) : (s < th);
            any_ok = any_ok || h;
            all_ok = all_ok && h;
        end
        return all ? all_ok : any_ok;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(output exp_t e);
        longint unsigned need;
        e = '0;
        if (reset) begin
            m_state = 0; m_q = 0; m_h = 0; m_ev = '0;
        end else if (!enable) begin
            m_state = 0; m_q = 0; m_h = 0;
        end else if (m_state == 0) begin
            if (adc_data_valid) begin
                if (qual(adc_data, start_threshold, polarity, all_lanes)) begin
                    need = (start_samples_number == 0) ? 1 : longint'(start_samples_number);
                    if (m_q + 1 >= need) begin
                        m_state = 1; m_q = 0; e.start = 1'b1; m_ev = m_ev + 1;
                    end else m_q = m_q + 1;
                end else m_q = 0;
            end
        end else if (m_state == 1) begin
            if (adc_data_valid) begin
                if (qual(adc_data, stop_threshold, !polarity, all_lanes)) begin
                    need = (stop_samples_number == 0) ? 1 : longint'(stop_samples_number);
                    if (m_q + 1 >= need) begin
                        m_state = 2; m_q = 0; m_h = longint'(holdoff_words); e.stop = 1'b1;
                    end else m_q = m_q + 1;
                end else m_q = 0;
            end
        end else begin
            if (m_h == 0) m_state = 0;
            else if (adc_data_valid) begin
                m_h = m_h - 1;
                if (m_h == 0) m_state = 0;
            end
        end
        e.sync = (m_state == 1);
        e.ev   = m_ev;
    endtask

    // Drive one cycle, queue the model's prediction, then compare after the edge.
    task automatic step(input logic [15:0] l0, input logic [15:0] l1, input logic v);
        exp_t e, got;
        adc_data       = {l1, l0};
        adc_data_valid = v;
        model_update(e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("sb_sync",  32'(sync),       32'(got.sync));
        check("sb_start", 32'(sync_start), 32'(got.start));
        check("sb_stop",  32'(sync_stop),  32'(got.stop));
        check("sb_event", event_count,     got.ev);
    endtask

    task automatic qw();
        step(16'h0800, 16'h0900, 1'b1);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; adc_data = '0; adc_data_valid = 1'b0;
        start_threshold = 16'h1000; stop_threshold = 16'h3000;
        start_samples_number = 3; stop_samples_number = 2; holdoff_words = 4;
        polarity = 1'b0; all_lanes = 1'b1;
        step(16'h0, 16'h0, 1'b0);
        step(16'h0, 16'h0, 1'b0);
        check("rst_sync",  32'(sync), 32'd0);
        check("rst_event", event_count, 32'd0);
        reset = 1'b0; enable = 1'b1;

        // Basic trigger after three qualifying words
        qw(); qw(); qw();
        check("t1_sync",  32'(sync),       32'd1);
        check("t1_start", 32'(sync_start), 32'd1);
        check("t1_event", event_count,     32'd1);

        // Stop, holdoff of four words, then re-trigger
        step(16'h4000, 16'h4000, 1'b1);
        step(16'h4000, 16'h4000, 1'b1);
        check("t3_stop", 32'(sync_stop), 32'd1);
        check("t3_sync", 32'(sync),      32'd0);
        qw(); qw(); qw(); qw();
        check("t3_hold_sync", 32'(sync), 32'd0);
        qw(); qw();
        check("t3_arm_sync", 32'(sync), 32'd0);
        qw();
        check("t3_retrig",  32'(sync),  32'd1);
        check("t3_event",   event_count, 32'd2);

        // Broken run does not trigger
        step(16'h4000, 16'h4000, 1'b1);
        step(16'h4000, 16'h4000, 1'b1);
        for (int i = 0; i < 4; i++) step(16'h2000, 16'h2000, 1'b1);
        qw(); qw();
        step(16'h0800, 16'h2000, 1'b1);
        check("t2_break", 32'(sync), 32'd0);
        qw(); qw();
        check("t2_partial", 32'(sync), 32'd0);
        qw();
        check("t2_trig",  32'(sync),  32'd1);
        check("t2_event", event_count, 32'd3);

        // Disable while active
        enable = 1'b0;
        step(16'h0, 16'h0, 1'b0);
        check("dis_sync",  32'(sync),      32'd0);
        check("dis_stop",  32'(sync_stop), 32'd0);
        check("dis_event", event_count,    32'd3);
        enable = 1'b1;

        // Any-lane, polarity 1, single word
        polarity = 1'b1; all_lanes = 1'b0; start_threshold = 16'h8000; start_samples_number = 1;
        step(16'h0001, 16'h9000, 1'b1);
        check("t4_any",   32'(sync),  32'd1);
        check("t4_event", event_count, 32'd4);
        enable = 1'b0;
        step(16'h0, 16'h0, 1'b0);
        enable = 1'b1; all_lanes = 1'b1;
        step(16'h0001, 16'h9000, 1'b1);
        check("t4_all", 32'(sync), 32'd0);

        // Valid gaps inside a qualifying run
        polarity = 1'b0; start_threshold = 16'h1000; start_samples_number = 4;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check("t5_before", 32'(sync), 32'd0);
            qw();
            if (i < 3) for (int j = 0; j < 5; j++) step(16'h2000, 16'h2000, 1'b0);
        end
        check("t5_trig",  32'(sync),  32'd1);
        check("t5_event", event_count, 32'd5);

        // Strict compare and start_n = 0
        enable = 1'b0;
        step(16'h0, 16'h0, 1'b0);
        enable = 1'b1; start_samples_number = 0;
        step(16'h1000, 16'h1000, 1'b1);
        check("eq_start", 32'(sync), 32'd0);
        step(16'h0FFF, 16'h0FFF, 1'b1);
        check("n0_trig",  32'(sync),  32'd1);
        check("n0_event", event_count, 32'd6);

        // Zero holdoff passes through in one cycle
        stop_samples_number = 1; holdoff_words = 0;
        step(16'h3000, 16'h3000, 1'b1);
        check("eq_stop", 32'(sync), 32'd1);
        step(16'h3001, 16'h3001, 1'b1);
        check("h0_stop", 32'(sync_stop), 32'd1);
        qw();
        check("h0_hold", 32'(sync), 32'd0);
        qw();
        check("h0_trig",  32'(sync),  32'd1);
        check("h0_event", event_count, 32'd7);

        // Reset mid-run
        reset = 1'b1;
        qw();
        check("mr_sync",  32'(sync),       32'd0);
        check("mr_start", 32'(sync_start), 32'd0);
        check("mr_event", event_count,     32'd0);
        reset = 1'b0;

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [15:0] vals [5];
            vals[0] = 16'h0800; vals[1] = 16'h1000; vals[2] = 16'h2000;
            vals[3] = 16'h3000; vals[4] = 16'h4000;
            if (i % 50 == 0) begin
                polarity             = 1'($urandom_range(0, 1));
                all_lanes            = 1'($urandom_range(0, 1));
                start_samples_number = 32'($urandom_range(0, 3));
                stop_samples_number  = 32'($urandom_range(0, 3));
                holdoff_words        = 32'($urandom_range(0, 3));
            end
            enable = ($urandom_range(0, 39) != 0);
            step(vals[$urandom_range(0, 4)], vals[$urandom_range(0, 4)],
                 1'($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/level_trigger.md
# level_trigger

Parametrised multi-lane level trigger for the ADC input path. It watches packed ADC words of `LANES` samples each and raises `sync` once enough consecutive words qualify against a start threshold. It drops `sync` once enough consecutive words qualify against a stop threshold, then waits out a programmable holdoff before re-arming. It sits between the ADC input deserialiser and the packetiser, and adds trigger polarity, an any/all lane mode, holdoff, event pulses and an event counter.

## Interface
- `SAMPLE_W`, 16: unsigned sample width.
- `LANES`, 2: samples per input word; lane k = `adc_data[k*SAMPLE_W +: SAMPLE_W]`.
- `CNT_W`, 32: width of the qualification counters, holdoff counter and event counter.
- `clk` input, 1: single clock. All logic is on the rising edge.
- `reset` input, 1: synchronous, active-high reset.
- `enable` input, 1: trigger enable. When low, the block is held in ARM.
- `adc_data` input, `LANES*SAMPLE_W`: packed unsigned samples.
- `adc_data_valid` input, 1: `adc_data` qualifier.
- `start_threshold`, `stop_threshold` input, `SAMPLE_W` each: compare levels.
- `start_samples_number`, `stop_samples_number` input, `CNT_W` each: number of consecutive qualifying words required. A value of 0 behaves as 1.
- `holdoff_words` input, `CNT_W`: number of valid words to skip after a stop before arming.
- `polarity` input, 1: 0 = start when below `start_threshold`, stop when above `stop_threshold`; 1 = the mirror (start above, stop below).
- `all_lanes` input, 1: 1 = every lane must meet the condition; 0 = any lane is enough.
- `sync` output, 1: packet synchronisation level.
- `sync_start` output, 1: one-cycle pulse when `sync` rises.
- `sync_stop` output, 1: one-cycle pulse when `sync` falls.
- `event_count` output, `CNT_W`: number of rising edges of `sync` since reset. Wraps modulo 2^CNT_W.

## Operation
- Per-lane conditions, strict comparisons:
  - polarity=0: start_k = s_k < start_threshold; stop_k = s_k > stop_threshold.
  - polarity=1: start_k = s_k > start_threshold; stop_k = s_k < stop_threshold.
- A word qualifies when its lane conditions, combined by AND (`all_lanes`=1) or OR (`all_lanes`=0), are true.
- Word qualification is only evaluated when `adc_data_valid`=1. Cycles with `adc_data_valid`=0 leave every counter unchanged.
- States:
  - ARM (`sync`=0): a qualifying start word increments `qcnt`; a non-qualifying word clears it. When a valid qualifying word makes qcnt+1 ≥ max(start_samples_number,1), go to ACTIVE and clear qcnt.
  - ACTIVE (`sync`=1): the same rule using stop_k and `stop_samples_number`. On completion go to HOLDOFF, clear qcnt and load `hcnt` = `holdoff_words`.
  - HOLDOFF (`sync`=0): each valid word decrements hcnt. When hcnt is 0, or on the valid word that makes it 0, go to ARM. `holdoff_words`=0 means the block passes straight through HOLDOFF in one cycle, with no valid word needed.
- `qcnt` saturates at 2^CNT_W−1 and never wraps.
- Thresholds, sample counts and mode inputs are sampled live every cycle. Changing them mid-count does not clear qcnt.
- `enable`=0: on the next edge go to ARM, clear qcnt and hcnt, and force `sync`=0. No `sync_stop` pulse is generated. `event_count` is kept.
- `reset`: state ARM; qcnt, hcnt and `event_count` = 0. All outputs are 0.

## Timing
- All outputs are registered.
- Latency is 1 cycle: `sync` and `sync_start` assert in the cycle after the clock edge that sampled the completing valid word. `sync_stop` behaves the same way for the stop transition.
- `event_count` increments in the same cycle `sync_start` is high.
- With N = start_samples_number, N back-to-back valid qualifying words at cycles 0..N−1 give `sync`=1 from cycle N.
- A non-qualifying valid word in the same cycle as would-be completion means no transition and qcnt = 0.
- `enable` falling in the same cycle as a completing word: disable wins.
- `reset` has priority over everything.

## Structure
- Package `level_trigger_pkg` holds:
  - `state_t` enum {ARM, ACTIVE, HOLDOFF}.
  - A function `lane_qualify(samples, threshold, above, all_lanes)` that is parametrised through its arguments.
- Sub-module `consec_counter`, parameter `CNT_W`: inputs `clr`, `valid`, `hit`, `target`; outputs `done`, `count`. The saturating consecutive-hit counter used for the qualification count.
- Top level contains the FSM, the holdoff counter, the pulse generation and the event counter.

## Test plan
- polarity=0, all_lanes=1, start_th=0x1000, start_n=3, words {0x0800,0x0900}×3 → `sync` and `sync_start` high in cycle 3, `event_count`=1.
- Same setup, words at cycles 0 and 1 qualify, word 2 = {0x0800,0x2000} → no trigger. Three further qualifying words → trigger.
- In ACTIVE, stop_th=0x3000, stop_n=2, holdoff=4, two words {0x4000,0x4000} → `sync_stop` pulse and `sync`=0. The next 4 valid start-qualifying words are ignored; the trigger fires only after start_n more qualifying words.
- all_lanes=0, polarity=1, start_th=0x8000, single word {0x0001,0x9000} with start_n=1 → `sync` rises. Same word with all_lanes=1 → no trigger.
- `adc_data_valid` gaps of 5 idle cycles inside a qualifying run with start_n=4 → trigger still fires on the 4th valid word.
- `enable` dropped while ACTIVE → `sync`=0 next cycle, no `sync_stop` pulse, `event_count` kept. A `reset` pulse mid-run → all outputs 0 and `event_count`=0.
